output_accum_buffer: RTL
========================

# output_accum_buffer

Parametrised output memory for the Winograd CNN datapath. It succeeds the fixed two-port, 512-bit, 128-entry output memory. It accepts NUM_PORTS result packages per cycle and either overwrites an entry or accumulates into it lane-wise with a pipelined read-modify-write, forwarding for back-to-back hazards, a hardware clear sweep, and scan access for testbench load/unload. It sits between the output transform stage and the scan chain.

## Interface
- DATA_W, 512, package width
- LANE_W, 32, signed lane width; LANES = DATA_W/LANE_W (must divide)
- DEPTH, 128, number of entries
- ADDR_W, $clog2(DEPTH), address width
- NUM_PORTS, 2, package ports
- SATURATE, 0, 0 = wrap-around lane add, 1 = signed saturation
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- scan_mode  input  2  00 SCAN_IN, 01 RUN, 10 CLEAR, 11 SCAN_OUT
- scan_valid  input  1  qualifies scan_in / scan_addr
- scan_addr  input  ADDR_W  scan entry address
- scan_in  input  DATA_W  scan write data
- scan_out  output  DATA_W  scan read data
- scan_out_valid  output  1  scan_out valid
- pkg_valid_in  input  NUM_PORTS  per-port package valid
- pkg_acc_in  input  NUM_PORTS  1 = accumulate, 0 = overwrite
- addr_in  input  NUM_PORTS*ADDR_W  port p at [p*ADDR_W +: ADDR_W]
- data_in  input  NUM_PORTS*DATA_W  port p at [p*DATA_W +: DATA_W]
- pkg_valid_out  output  NUM_PORTS  update-done strobe
- addr_out  output  NUM_PORTS*ADDR_W  address of completed update
- data_out  output  NUM_PORTS*DATA_W  value written by that port
- ready  output  1  packages accepted this cycle
- busy  output  1  clear sweep in progress

## Operation
- Storage: DEPTH x DATA_W register array. reset does not clear it; only CLEAR or scan writes change it.
- ready = (scan_mode == RUN) && !busy. Packages with ready low are dropped. Upstream must hold them.
- Stage S1 (accept edge): register valid, acc, addr and data. Read the current entry, with forwarding from S2's same-edge write when addresses match.
- Stage S2: compute the new value and write it to the array. Drive the *_out signals for the completed updates.
- Intra-cycle ordering: ports are applied sequentially in ascending index.
  - Port p sees the result of any lower port with the same address.
  - Overwrite → value = data_in[p].
  - Accumulate → lane-wise add of data_in[p] to the running value.
- The array receives only the final value per address. Each port's data_out is its own intermediate result.
- Lane add: signed LANE_W. SATURATE=0 wraps modulo 2^LANE_W. SATURATE=1 clamps to [-2^(LANE_W-1), 2^(LANE_W-1)-1].
- CLEAR:
  - Sampled while !busy: busy goes high and a counter writes zero to entries 0..DEPTH-1, one per cycle.
  - busy falls after the entry DEPTH-1 write.
  - Leaving CLEAR mode mid-sweep does not stop the sweep.
  - CLEAR held after completion restarts the sweep on the following cycle.
- SCAN_IN: scan_valid writes scan_in to scan_addr at the edge.
- SCAN_OUT: scan_valid registers a read. scan_out and scan_out_valid follow one cycle later. scan_out = 0 when not valid.
- In-flight packages always drain through S2 regardless of scan_mode.
- Same-edge write collision: scan write > S2 write > clear write. A SCAN_OUT read returns the pre-edge content.
- States: IDLE, CLEARING.
  - IDLE→CLEARING when scan_mode == CLEAR.
  - CLEARING→IDLE when counter == DEPTH-1.
  - reset → IDLE.

## Timing
- Package accepted at edge N; the array is updated and pkg_valid_out/addr_out/data_out are asserted for one cycle after edge N+1. Latency 2, throughput 1 package per port per cycle.
- Back-to-back accumulates to the same address on consecutive cycles are correct via forwarding, with no stall.
- Reset values:
  - pkg_valid_out = 0, addr_out = 0, data_out = 0
  - scan_out = 0, scan_out_valid = 0
  - busy = 0, counter = 0
  - S1/S2 valids = 0
- Reset mid-sweep aborts the sweep; partially cleared entries keep their values. Reset discards in-flight packages with no write.
- Clear: busy is high for exactly DEPTH cycles.

## Test plan
- Scan in 0x…0005 (all lanes 5) at addr 3. Send port0 accumulate of all-lanes 2 to addr 3 → data_out[0] lanes = 7 at latency 2; scan out addr 3 = 7.
- Port0 accumulate 1 to addr 9 on 4 consecutive cycles from zero → data_out sequence 1, 2, 3, 4; final entry 4 (forwarding check).
- Same cycle: port0 overwrite 10 and port1 accumulate 3, both to addr 5 → data_out[0] = 10, data_out[1] = 13, entry = 13.
- SATURATE=1: lane 0x7FFFFFFF + 1 → 0x7FFFFFFF. SATURATE=0 → 0x80000000.
- CLEAR for 1 cycle at DEPTH=128 → busy high 128 cycles and ready low; packages are dropped; every entry scans out 0.
- Reset asserted at clear counter 40 → busy = 0 next cycle; entries ≥40 retain their prior values; pkg_valid_out = 0.

Source files
------------

// File: rtl/output_accum_buffer.sv
// Output accumulation memory for the Winograd datapath: NUM_PORTS packages per cycle, each
// overwriting or lane-wise accumulating into an entry via a 2-stage read-modify-write.
module output_accum_buffer #(
   parameter int DATA_W    = 512,
   parameter int LANE_W    = 32,
   parameter int DEPTH     = 128,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int NUM_PORTS = 2,
   parameter int SATURATE  = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  scan_mode,
   input  logic                        scan_valid,
   input  logic [ADDR_W-1:0]           scan_addr,
   input  logic [DATA_W-1:0]           scan_in,
   output logic [DATA_W-1:0]           scan_out,
   output logic                        scan_out_valid,
   input  logic [NUM_PORTS-1:0]        pkg_valid_in,
   input  logic [NUM_PORTS-1:0]        pkg_acc_in,
   input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
   input  logic [NUM_PORTS*DATA_W-1:0] data_in,
   output logic [NUM_PORTS-1:0]        pkg_valid_out,
   output logic [NUM_PORTS*ADDR_W-1:0] addr_out,
   output logic [NUM_PORTS*DATA_W-1:0] data_out,
   output logic                        ready,
   output logic                        busy
);

   localparam int LANES = DATA_W / LANE_W;

   localparam logic [1:0] M_SCAN_IN  = 2'b00;
   localparam logic [1:0] M_RUN      = 2'b01;
   localparam logic [1:0] M_CLEAR    = 2'b10;
   localparam logic [1:0] M_SCAN_OUT = 2'b11;

   typedef enum logic {IDLE, CLEARING} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [NUM_PORTS-1:0][ADDR_W-1:0] in_addr;
   logic [NUM_PORTS-1:0][DATA_W-1:0] in_data;

   // vld_pipe[0]: S1 holds accepted packages; vld_pipe[1]: S2 drives the completion strobes
   logic [NUM_PORTS-1:0]             vld_pipe [1:0];
   logic [NUM_PORTS-1:0]             s1_acc;
   logic [NUM_PORTS-1:0][ADDR_W-1:0] s1_addr;
   logic [NUM_PORTS-1:0][DATA_W-1:0] s1_data;
   logic [NUM_PORTS-1:0][DATA_W-1:0] s1_rd;

   logic [NUM_PORTS-1:0][DATA_W-1:0] res;
   logic [NUM_PORTS-1:0][DATA_W-1:0] rd_nxt;

   logic [NUM_PORTS-1:0][ADDR_W-1:0] out_addr;
   logic [NUM_PORTS-1:0][DATA_W-1:0] out_data;

   assign in_addr       = addr_in;
   assign in_data       = data_in;
   assign addr_out      = out_addr;
   assign data_out      = out_data;
   assign pkg_valid_out = vld_pipe[1];
   assign busy          = (state == CLEARING);
   assign ready         = (scan_mode == M_RUN) && !busy;

   function automatic logic [DATA_W-1:0] vec_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [LANE_W:0]   s;
      logic [DATA_W-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++) begin
         s = {a[l*LANE_W + LANE_W-1], a[l*LANE_W +: LANE_W]} +
             {b[l*LANE_W + LANE_W-1], b[l*LANE_W +: LANE_W]};
         // sign bit disagreeing with the extra carry bit means signed overflow
         if ((SATURATE != 0) && (s[LANE_W] != s[LANE_W-1]))
            r[l*LANE_W +: LANE_W] = s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                              : {1'b0, {(LANE_W-1){1'b1}}};
         else
            r[l*LANE_W +: LANE_W] = s[LANE_W-1:0];
      end
      return r;
   endfunction

   // Ports resolve in ascending order; rd_nxt forwards the final value S2 writes this edge.
   always_comb begin
      logic [DATA_W-1:0] run;
      res    = '0;
      rd_nxt = '0;
      run    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         run = s1_rd[p];
         for (int q = 0; q < p; q++)
            if (vld_pipe[0][q] && (s1_addr[q] == s1_addr[p]))
               run = res[q];
         res[p] = s1_acc[p] ? vec_add(run, s1_data[p]) : s1_data[p];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         rd_nxt[p] = mem[in_addr[p]];
         for (int q = 0; q < NUM_PORTS; q++)
            if (vld_pipe[0][q] && (s1_addr[q] == in_addr[p]))
               rd_nxt[p] = res[q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe[0] <= '0;
         vld_pipe[1] <= '0;
         s1_acc      <= '0;
         s1_addr     <= '0;
         s1_data     <= '0;
         s1_rd       <= '0;
         out_addr    <= '0;
         out_data    <= '0;
      end else begin
         vld_pipe[0] <= ready ? pkg_valid_in : '0;
         vld_pipe[1] <= vld_pipe[0];
         s1_acc      <= pkg_acc_in;
         s1_addr     <= in_addr;
         s1_data     <= in_data;
         s1_rd       <= rd_nxt;
         for (int p = 0; p < NUM_PORTS; p++) begin
            out_addr[p] <= vld_pipe[0][p] ? s1_addr[p] : '0;
            out_data[p] <= vld_pipe[0][p] ? res[p] : '0;
         end
      end
   end

   // Later assignments win: clear, then package results (highest port last), then scan.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (busy)
            mem[cnt] <= '0;
         for (int p = 0; p < NUM_PORTS; p++)
            if (vld_pipe[0][p])
               mem[s1_addr[p]] <= res[p];
      end
      if ((scan_mode == M_SCAN_IN) && scan_valid)
         mem[scan_addr] <= scan_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_out       <= '0;
         scan_out_valid <= 1'b0;
      end else if ((scan_mode == M_SCAN_OUT) && scan_valid) begin
         scan_out       <= mem[scan_addr];
         scan_out_valid <= 1'b1;
      end else begin
         scan_out       <= '0;
         scan_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (scan_mode == M_CLEAR) begin
               state_nxt = CLEARING;
               cnt_nxt   = '0;
            end
         end
         CLEARING: begin
            if (cnt == ADDR_W'(DEPTH-1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule
